// File: rtl/mdu_pipe.sv
// Multiply/divide unit for the EX stage: multi-cycle mult/div with HI/LO result registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             cancel,
    output logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;
`endif

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic              op_is_start;
    logic              mul_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
    logic              is_div, div_signed, a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

    assign Busy  = (state_q == StBusy);
    assign Start = op_is_start && !cancel && !Busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Decode which incoming ops launch a multi-cycle operation
    always_comb begin
        op_is_start = 1'b0;
        case (Op)
            OpMult, OpMultu, OpDiv, OpDivu: op_is_start = 1'b1;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu, OpMsub, OpMsubu: op_is_start = 1'b1;
`endif
            default: op_is_start = 1'b0;
        endcase
    end

    // Multiply datapath on latched operands; sign-extend then take the low 2*WIDTH bits
    always_comb begin
        mul_signed = (op_q == OpMult);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OpMadd) || (op_q == OpMsub);
`endif
        a_ext   = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = prod;
`ifdef MDU_MADD_EN
        // Accumulate against HI/LO as they stand at commit
        case (op_q)
            OpMadd, OpMaddu: mul_res = {hi_q, lo_q} + prod;
            OpMsub, OpMsubu: mul_res = {hi_q, lo_q} - prod;
            default:         mul_res = prod;
        endcase
`endif
    end

    // Divide on magnitudes; negating the most-negative value yields itself, which makes
    // MIN / -1 come out as quotient MIN, remainder 0 with no special case
    always_comb begin
        is_div     = (op_q == OpDiv) || (op_q == OpDivu);
        div_signed = (op_q == OpDiv);
        a_neg      = div_signed && a_q[WIDTH-1];
        b_neg      = div_signed && b_q[WIDTH-1];
        a_mag      = a_neg ? -a_q : a_q;
        b_mag      = b_neg ? -b_q : b_q;
        b_div      = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem        = a_neg ? -r_mag : r_mag;
    end

    // Next-state: launch, count down, commit; mthi/mtlo only while idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = Op;
                    cnt_d   = ((Op == OpDiv) || (Op == OpDivu)) ? CntW'(DIV_CYCLES)
                                                                : CntW'(MULT_CYCLES);
                    state_d = StBusy;
                end else if (!cancel && (Op == OpMthi)) begin
                    hi_d = A;
                end else if (!cancel && (Op == OpMtlo)) begin
                    lo_d = A;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (is_div) begin
                        // Divide by zero leaves HI/LO untouched
                        if (b_q != '0) begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe: directed scenarios plus randomized ops against a
// transaction-level model (results computed with plain integer arithmetic at commit).
module tb_mdu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  Op = '0;
    logic        cancel = 1'b0;
    logic        Start, Busy;
    logic [31:0] hi, lo;

    mdu_pipe #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .Op(Op),
        .cancel(cancel),
        .Start(Start),
        .Busy(Busy),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MDU_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, pending operation
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_busy = 0;
    logic [3:0]  p_op;
    logic [31:0] p_a, p_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit starts(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MaddEn && op >= 4'd9 && op <= 4'd12);
    endfunction

    // Architectural effect of a finished operation on HI/LO
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        sa = a;
        sb = b;
        case (op)
            4'd1:  {m_hi, m_lo} = sp;
            4'd2:  {m_hi, m_lo} = up;
            4'd3: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = a;
                        m_hi = 0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            4'd4: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd9:  {m_hi, m_lo} = {m_hi, m_lo} + sp;
            4'd10: {m_hi, m_lo} = {m_hi, m_lo} + up;
            4'd11: {m_hi, m_lo} = {m_hi, m_lo} - sp;
            4'd12: {m_hi, m_lo} = {m_hi, m_lo} - up;
            default: ;
        endcase
    endtask

    // One clock: drive at posedge+1, check Start, then check state after the edge
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        bit exp_start;
        Op = op;
        A = a;
        B = b;
        cancel = c;
        #1;
        exp_start = starts(op) && !c && (m_busy == 0);
        check("start", {63'b0, Start}, {63'b0, exp_start});
        @(posedge clk);
        #1;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) apply(p_op, p_a, p_b);
        end else if (exp_start) begin
            m_busy = (op == 4'd3 || op == 4'd4) ? 10 : 5;
            p_op = op;
            p_a = a;
            p_b = b;
        end else if (!c && op == 4'd7) begin
            m_hi = a;
        end else if (!c && op == 4'd8) begin
            m_lo = a;
        end
        check("busy", {63'b0, Busy}, {63'b0, m_busy > 0});
        check("hi", {32'b0, hi}, {32'b0, m_hi});
        check("lo", {32'b0, lo}, {32'b0, m_lo});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, $urandom, $urandom, 1'b0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear immediately
    task automatic pulse_reset();
        Op = 4'd0;
        cancel = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_busy = 0;
        m_hi = '0;
        m_lo = '0;
        check("rst_busy", {63'b0, Busy}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        c;

        @(posedge clk);
        #1;
        check("init_busy", {63'b0, Busy}, 64'd0);
        check("init_hi", {32'b0, hi}, 64'd0);
        check("init_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;

        // Signed multiply with negative operand
        cycle(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(5);
        check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'b0, lo}, 64'hFFFF_FFFA);

        // Unsigned and signed divide
        cycle(4'd4, 32'd7, 32'hFFFF_FFFF, 1'b0);
        idle(10);
        check("divu_lo", {32'b0, lo}, 64'd0);
        check("divu_hi", {32'b0, hi}, 64'd7);
        cycle(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10);
        check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        // Moves, then divide by zero keeps HI/LO
        cycle(4'd7, 32'h1234, 32'd0, 1'b0);
        cycle(4'd8, 32'h5678, 32'd0, 1'b0);
        check("mthi", {32'b0, hi}, 64'h1234);
        check("mtlo", {32'b0, lo}, 64'h5678);
        cycle(4'd3, 32'd5, 32'd0, 1'b0);
        idle(10);
        check("div0_hi", {32'b0, hi}, 64'h1234);
        check("div0_lo", {32'b0, lo}, 64'h5678);

        // Most-negative / -1
        cycle(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10);
        check("ovf_lo", {32'b0, lo}, 64'h8000_0000);
        check("ovf_hi", {32'b0, hi}, 64'd0);

        // Cancelled start, then cancel mid-operation does not abort
        cycle(4'd1, 32'd2, 32'd3, 1'b1);
        cycle(4'd1, 32'd2, 32'd3, 1'b0);
        cycle(4'd0, 32'd0, 32'd0, 1'b0);
        cycle(4'd8, 32'hDEAD, 32'd0, 1'b1);
        idle(3);
        check("cancel_lo", {32'b0, lo}, 64'd6);

        // mtlo while busy is ignored, then reset in the 4th busy cycle
        cycle(4'd3, 32'd100, 32'd7, 1'b0);
        cycle(4'd8, 32'hBEEF, 32'd0, 1'b0);
        idle(2);
        check("busy_mtlo", {32'b0, lo}, 64'd6);
        pulse_reset();
        idle(2);

        // Accumulate (or nop when the feature is absent)
        cycle(4'd7, 32'd0, 32'd0, 1'b0);
        cycle(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
        cycle(4'd10, 32'd1, 32'd1, 1'b0);
        idle(5);
        if (MaddEn) begin
            check("maddu_hi", {32'b0, hi}, 64'd1);
            check("maddu_lo", {32'b0, lo}, 64'd0);
        end else begin
            check("maddu_hi", {32'b0, hi}, 64'd0);
            check("maddu_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            c = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else cycle(op, a, b, c);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core.
- Successor to the fixed 32-bit MDU, adding:
  - configurable operand width and per-class latency;
  - a cancel input for interrupt flush;
  - defined divide corner cases;
  - optional multiply-accumulate ops.
- The hazard unit stalls on Start|Busy; HI/LO are read via Op 5/6.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub; must be >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >=1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- A  in  WIDTH  operand rs (forwarded)
- B  in  WIDTH  operand rt (forwarded)
- Op  in  4  0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu, 13-15 nop
- cancel  in  1  interrupt flush; suppresses the effect of Op this cycle
- Start  out  1  combinational: Op is a start-type op (1-4, 9-12 when enabled) and !cancel and !Busy
- Busy  out  1  registered: operation in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation):
  - hi=0, lo=0, Busy=0, counter=0.
  - Any pending result is discarded.
- State machine:
  - IDLE:
    - On an edge with Start=1: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - BUSY:
    - Busy=1; counter decrements every edge.
    - On the edge where counter==1: commit result to hi/lo, Busy->0, return to IDLE.
  - Latency: start sampled at edge k -> Busy=1 after k through k+N-1 -> hi/lo new and Busy=0 after edge k+N.
- Ops arriving while Busy (start types and mthi/mtlo) are ignored; hi/lo stay stable until commit.
- mthi/mtlo when IDLE and !cancel: hi<=A or lo<=A at the same edge; single cycle, Busy unaffected.
- Op 5/6 and nops have no state effect; hi/lo are always readable.
- cancel=1: the current-cycle Op has no effect. A BUSY operation already running is NOT aborted: the instruction preceded the interrupt and must complete.
- Arithmetic (operands latched at start, products 2*WIDTH):
  - mult/multu: {hi,lo} = A*B, signed/unsigned.
  - madd(u): {hi,lo} += A*B, using the {hi,lo} values at commit.
  - msub(u): {hi,lo} -= A*B, using the {hi,lo} values at commit. Wrap modulo 2^(2*WIDTH).
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - B==0 (div, divu): hi and lo unchanged at commit; Busy timing identical.
  - div with A = most-negative and B = -1: lo = most-negative, hi = 0.
- Simultaneous reset and Start: reset wins.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 9-12 behave as above and assert Start.
- Undefined: ops 9-12 are nops (Start=0, no state change); multiply datapath has no accumulate adder.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> Start=1 for one cycle; Busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu A=7, B=0xFFFFFFFF -> Busy 10 cycles; then lo=0, hi=7. Next, div A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi A=0x1234, then mtlo A=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 each one edge later; div A=5, B=0 -> after 10 busy cycles hi=0x1234, lo=0x5678.
- mult A=2, B=3 with cancel=1 in its cycle -> Start=0, Busy stays 0, hi/lo unchanged. Start mult A=2, B=3, assert cancel during cycle 2 of BUSY -> completes; lo=6.
- Start div, then reset pulse in the 4th busy cycle -> Busy=0, hi=lo=0 immediately; mtlo issued while Busy in a prior run -> ignored.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu A=1, B=1 -> hi=1, lo=0. Without the macro: same Op=10 -> Start=0 and hi/lo unchanged.
